// File: rtl/mw_skid_stage.sv
// MEM/WB-class pipeline stage: valid/ready register with a two-entry skid buffer,
// synchronous flush and x0-write suppression. Optional counters under MW_STAGE_PERF_EN.
module mw_skid_stage #(
   parameter int DATA_W = 160,
   parameter int CTRL_W = 6,
   parameter int RD_W   = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              in_regwrite,
   input  logic [RD_W-1:0]   in_rd,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_regwrite,
   output logic [RD_W-1:0]   out_rd,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [DATA_W-1:0] out_data
`ifdef MW_STAGE_PERF_EN
   ,
   output logic [31:0]       stall_cnt,
   output logic [31:0]       flush_cnt
`endif
);

   localparam int ENT_W = 1 + RD_W + CTRL_W + DATA_W;

   // Entry layout {wen, rd, ctrl, data}; wen is already qualified against x0.
   function automatic logic qualify_wen(input logic regwrite, input logic [RD_W-1:0] rd);
      qualify_wen = regwrite & (rd != {RD_W{1'b0}});
   endfunction

   logic             main_valid_q, main_valid_d;
   logic             skid_valid_q, skid_valid_d;
   logic [ENT_W-1:0] main_q, main_d;
   logic [ENT_W-1:0] skid_q, skid_d;
   logic [ENT_W-1:0] in_entry_s;
   logic             accept_s;
   logic             emit_s;

   assign in_entry_s = {qualify_wen(in_regwrite, in_rd), in_rd, in_ctrl, in_data};
   assign accept_s   = in_valid & ~skid_valid_q;
   assign emit_s     = main_valid_q & out_ready;

   assign in_ready     = ~skid_valid_q;
   assign out_valid    = main_valid_q;
   assign out_regwrite = main_valid_q & main_q[ENT_W-1];
   assign out_rd       = main_q[ENT_W-2 -: RD_W];
   assign out_ctrl     = main_q[CTRL_W+DATA_W-1 -: CTRL_W];
   assign out_data     = main_q[DATA_W-1:0];

   // Occupancy next-state: main is always the older entry, skid only fills behind it.
   always_comb begin
      main_valid_d = main_valid_q;
      skid_valid_d = skid_valid_q;
      main_d       = main_q;
      skid_d       = skid_q;
      if (flush) begin
         main_valid_d = 1'b0;
         skid_valid_d = 1'b0;
      end else begin
         case ({main_valid_q, skid_valid_q})
            2'b00: begin
               if (accept_s) begin
                  main_valid_d = 1'b1;
                  main_d       = in_entry_s;
               end else begin
                  main_valid_d = 1'b0;
               end
            end
            2'b10: begin
               if (accept_s & emit_s) begin
                  main_d = in_entry_s;
               end else if (accept_s) begin
                  skid_valid_d = 1'b1;
                  skid_d       = in_entry_s;
               end else if (emit_s) begin
                  main_valid_d = 1'b0;
               end else begin
                  main_valid_d = 1'b1;
               end
            end
            2'b11: begin
               if (emit_s) begin
                  main_d       = skid_q;
                  skid_valid_d = 1'b0;
               end else begin
                  skid_valid_d = 1'b1;
               end
            end
            default: begin
               main_valid_d = 1'b0;
               skid_valid_d = 1'b0;
            end
         endcase
      end
   end

   // State registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         main_valid_q <= 1'b0;
         skid_valid_q <= 1'b0;
         main_q       <= {ENT_W{1'b0}};
         skid_q       <= {ENT_W{1'b0}};
      end else begin
         main_valid_q <= main_valid_d;
         skid_valid_q <= skid_valid_d;
         main_q       <= main_d;
         skid_q       <= skid_d;
      end
   end

`ifdef MW_STAGE_PERF_EN
   logic [31:0] stall_cnt_q;
   logic [31:0] flush_cnt_q;

   // Stall and flush event counters, free-running with natural wrap.
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt_q <= 32'd0;
         flush_cnt_q <= 32'd0;
      end else begin
         if (main_valid_q & ~out_ready) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
         end
         if (flush & (main_valid_q | skid_valid_q)) begin
            flush_cnt_q <= flush_cnt_q + 32'd1;
         end
      end
   end

   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_mw_skid_stage.sv
// Randomised bench for mw_skid_stage against a two-deep FIFO reference model.
module tb_mw_skid_stage;

   localparam int DW = 160;
   localparam int CW = 6;
   localparam int RW = 5;
   localparam int EW = 1 + RW + CW + DW;
   localparam int OW = 3 + RW + CW + DW;

   logic          clk = 1'b0;
   logic          rst;
   logic          flush;
   logic          in_valid;
   logic          in_ready;
   logic          in_regwrite;
   logic [RW-1:0] in_rd;
   logic [CW-1:0] in_ctrl;
   logic [DW-1:0] in_data;
   logic          out_valid;
   logic          out_ready;
   logic          out_regwrite;
   logic [RW-1:0] out_rd;
   logic [CW-1:0] out_ctrl;
   logic [DW-1:0] out_data;
`ifdef MW_STAGE_PERF_EN
   logic [31:0]   stall_cnt;
   logic [31:0]   flush_cnt;
`endif

   always #5 clk = ~clk;

   mw_skid_stage #(.DATA_W(DW), .CTRL_W(CW), .RD_W(RW)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_regwrite(in_regwrite),
      .in_rd(in_rd), .in_ctrl(in_ctrl), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_regwrite(out_regwrite),
      .out_rd(out_rd), .out_ctrl(out_ctrl), .out_data(out_data)
`ifdef MW_STAGE_PERF_EN
      , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
   );

   int checks = 0;
   int errors = 0;

   // Reference: a FIFO holding at most two raw entries {regwrite, rd, ctrl, data}.
   logic [EW-1:0] mq[$];
   int unsigned   m_stall = 0;
   int unsigned   m_flush = 0;

   function automatic logic [OW-1:0] observe();
      observe = {in_ready, out_valid, out_regwrite,
                 out_valid ? {out_rd, out_ctrl, out_data} : {(RW+CW+DW){1'b0}}};
   endfunction

   function automatic logic [OW-1:0] expect_vec();
      logic [EW-1:0] h;
      logic          v;
      logic          wen;
      v = (mq.size() > 0);
      h = {EW{1'b0}};
      if (v) h = mq[0];
      wen = v && h[EW-1] && (h[EW-2 -: RW] != {RW{1'b0}});
      expect_vec = {(mq.size() < 2), v, wen, v ? h[EW-2:0] : {(RW+CW+DW){1'b0}}};
   endfunction

   function automatic logic [DW-1:0] rand_data();
      rand_data = {$urandom, $urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic drive(input logic v, input logic rw, input logic [RW-1:0] rd,
                        input logic ordy, input logic fl);
      in_valid    = v;
      in_regwrite = rw;
      in_rd       = rd;
      in_ctrl     = CW'($urandom);
      in_data     = rand_data();
      out_ready   = ordy;
      flush       = fl;
   endtask

   // Advance one clock, updating the reference from the inputs present at the edge.
   task automatic tick();
      logic acc;
      logic em;
      acc = in_valid && (mq.size() < 2);
      em  = (mq.size() > 0) && out_ready;
      @(posedge clk);
      if (rst) begin
         mq.delete();
         m_stall = 0;
         m_flush = 0;
      end else begin
         if (flush && mq.size() > 0) m_flush++;
         if (mq.size() > 0 && !out_ready) m_stall++;
         if (flush) begin
            mq.delete();
         end else begin
            if (em) void'(mq.pop_front());
            if (acc) mq.push_back({in_regwrite, in_rd, in_ctrl, in_data});
         end
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      drive(1'b1, 1'b1, 5'd9, 1'b1, 1'b0);
      in_data = {20{8'hA5}};
      tick();
      tick();
      checks++;
      if ({in_ready, out_valid, out_regwrite, out_rd, out_ctrl, out_data} !==
          {1'b1, 1'b0, 1'b0, {(RW+CW+DW){1'b0}}}) begin
         errors++;
         $display("FAIL reset got rdy=%b v=%b rw=%b rd=%0d data=%h exp rdy=1 v=0 rw=0 rd=0 data=0",
                  in_ready, out_valid, out_regwrite, out_rd, out_data);
      end
      rst = 1'b0;
      drive(1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
      tick();
      checks++;
      if (observe() !== expect_vec()) begin
         errors++;
         $display("FAIL reset_idle got %h exp %h", observe(), expect_vec());
      end
   endtask

   task automatic test_streaming();
      for (int i = 0; i < 4; i++) begin
         if (i < 3) drive(1'b1, 1'b1, RW'(3 + i), 1'b1, 1'b0);
         else drive(1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
         tick();
         checks++;
         if (observe() !== expect_vec()) begin
            errors++;
            $display("FAIL stream cycle %0d got %h exp %h", i, observe(), expect_vec());
         end
         checks++;
         if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL stream_ready cycle %0d got %b exp 1", i, in_ready);
         end
      end
   endtask

   task automatic test_backpressure();
      logic [DW-1:0] items[3];
      int idx = 0;
      int emits = 0;
      for (int k = 0; k < 3; k++) items[k] = rand_data();
      for (int cyc = 0; cyc < 12; cyc++) begin
         drive(idx < 3, 1'b1, RW'(10 + idx), cyc >= 4, 1'b0);
         if (idx < 3) in_data = items[idx];
         if (out_valid === 1'b1 && out_ready === 1'b1) emits++;
         if (in_valid && mq.size() < 2) idx++;
         tick();
         checks++;
         if (observe() !== expect_vec()) begin
            errors++;
            $display("FAIL backpressure cycle %0d got %h exp %h", cyc, observe(), expect_vec());
         end
         if (cyc == 1) begin
            checks++;
            if (in_ready !== 1'b0) begin
               errors++;
               $display("FAIL bp_full_ready got %b exp 0", in_ready);
            end
         end
      end
      checks++;
      if (emits != 3) begin
         errors++;
         $display("FAIL bp_emit_count got %0d exp 3", emits);
      end
   endtask

   task automatic test_x0();
      drive(1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
      tick();
      drive(1'b1, 1'b1, 5'd0, 1'b1, 1'b0);
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_regwrite !== 1'b0) begin
         errors++;
         $display("FAIL x0_suppress got v=%b rw=%b exp v=1 rw=0", out_valid, out_regwrite);
      end
      drive(1'b1, 1'b1, 5'd7, 1'b1, 1'b0);
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_regwrite !== 1'b1 || out_rd !== 5'd7) begin
         errors++;
         $display("FAIL x7_write got v=%b rw=%b rd=%0d exp v=1 rw=1 rd=7", out_valid, out_regwrite, out_rd);
      end
      checks++;
      if (observe() !== expect_vec()) begin
         errors++;
         $display("FAIL x0_model got %h exp %h", observe(), expect_vec());
      end
   endtask

   task automatic test_flush();
      drive(1'b1, 1'b1, 5'd1, 1'b0, 1'b0);
      tick();
      drive(1'b1, 1'b1, 5'd2, 1'b0, 1'b0);
      tick();
      drive(1'b1, 1'b1, 5'd3, 1'b0, 1'b1);
      tick();
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL flush_full got v=%b rdy=%b exp v=0 rdy=1", out_valid, in_ready);
      end
      for (int i = 0; i < 4; i++) begin
         if (i < 3) drive(1'b1, 1'b1, RW'(20 + i), 1'b1, 1'b0);
         else drive(1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
         tick();
         checks++;
         if (observe() !== expect_vec()) begin
            errors++;
            $display("FAIL post_flush cycle %0d got %h exp %h", i, observe(), expect_vec());
         end
      end
`ifdef MW_STAGE_PERF_EN
      checks++;
      if (flush_cnt !== 32'(m_flush) || stall_cnt !== 32'(m_stall)) begin
         errors++;
         $display("FAIL perf_flush got f=%0d s=%0d exp f=%0d s=%0d", flush_cnt, stall_cnt, m_flush, m_stall);
      end
`endif
   endtask

   task automatic test_random();
      for (int cyc = 0; cyc < 800; cyc++) begin
         drive($urandom_range(0, 9) < 7, 1'($urandom), RW'($urandom_range(0, 7)),
               $urandom_range(0, 9) < 6, $urandom_range(0, 15) == 0);
         tick();
         checks++;
         if (observe() !== expect_vec()) begin
            errors++;
            $display("FAIL random cycle %0d got %h exp %h", cyc, observe(), expect_vec());
         end
      end
`ifdef MW_STAGE_PERF_EN
      checks++;
      if (flush_cnt !== 32'(m_flush) || stall_cnt !== 32'(m_stall)) begin
         errors++;
         $display("FAIL perf_random got f=%0d s=%0d exp f=%0d s=%0d", flush_cnt, stall_cnt, m_flush, m_stall);
      end
`endif
   endtask

   initial begin
      rst = 1'b1;
      drive(1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
      test_reset();
      test_streaming();
      test_backpressure();
      test_x0();
      test_flush();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
